reg_bus_arbiter: RTL and testbench
==================================

Name: reg_bus_arbiter

Overview:
- Shares a bank of NREG 16-bit registers (each with write/inc/datain controls) between NREQ requesters, e.g. the control unit, a debug port and a DMA engine.
- Each requester posts a single op: load a register or increment it. The block arbitrates round-robin and drives exactly one register enable for one cycle per granted op.
- An optional per-requester lock holds the bank for an atomic multi-op sequence, bounded by a timeout.

Parameters:
- NREQ, 2, number of requesters (2..8).
- NREG, 8, number of registers in the bank.
- DW, 16, register data width.
- AW, 3, register address width; NREG <= 2**AW.
- LOCK_MAX, 64, maximum cycles a lock may be held in LOCKED before forced release.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request; held until the matching gnt bit.
- op  in  NREQ  per-requester op: 1 = write (load wdata), 0 = inc.
- addr  in  NREQ*AW  packed target register index; requester i uses slice [i*AW +: AW].
- wdata  in  NREQ*DW  packed write data; requester i uses slice [i*DW +: DW].
- lock  in  NREQ  request to keep ownership after the current grant.
- gnt  out  NREQ  one-hot, one-cycle pulse; the op is issued in that same cycle.
- reg_write  out  NREG  one-hot write enable to the register bank.
- reg_inc  out  NREG  one-hot increment enable to the register bank.
- reg_datain  out  DW  shared data bus to all registers' datain.
- busy  out  1  high in ISSUE and LOCKED.
- addr_err  out  1  one-cycle pulse when a granted addr >= NREG.
- lock_err  out  1  one-cycle pulse on lock timeout.

Behaviour:
- All outputs are registered.
- Reset: state IDLE; rr pointer = 0; owner = 0; lock counter = 0. gnt, reg_write, reg_inc, reg_datain, busy, addr_err and lock_err are all 0. Reset mid-operation aborts everything: no enable fires in the cycle after reset, and any pending op is dropped.
- IDLE:
  - If any req bit is set, pick the first set bit searching from the pointer upward, wrapping modulo NREQ.
  - Capture the winner's op, addr and wdata into the owner index; next state ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE (exactly one cycle):
  - gnt[owner]=1.
  - If addr < NREG: reg_write[addr]=op and reg_inc[addr]=~op. reg_datain = captured wdata for a write, 0 for an inc.
  - If addr >= NREG: no enable fires; addr_err=1; gnt is still given.
  - Pointer <= (owner+1) mod NREQ.
  - Next state is LOCKED if lock[owner]=1 in this cycle, otherwise IDLE. The lock counter clears on entry to LOCKED.
- LOCKED:
  - Only the owner is served; all other req bits are ignored.
  - If lock[owner]=0: next state IDLE.
  - Else if req[owner]=1: capture the owner's op, addr and wdata; next state ISSUE.
  - Else: the counter increments. When the counter reaches LOCK_MAX-1: lock_err=1 for one cycle, next state IDLE.
- Throughput: one op per 2 cycles, in both unlocked and locked operation. Request-to-enable latency is 1 cycle from the arbitration cycle.
- Requester rules:
  - req, op, addr and wdata stay stable until gnt.
  - The requester may drop req, or present a new op, in the cycle after gnt.
  - req[i] must not fall before gnt[i]; if it does, the captured op still issues.
- Simultaneous requests: round-robin gives no starvation; the worst-case wait for an unlocked requester is NREQ-1 ops plus any lock period.
- When not in ISSUE: reg_write=0, reg_inc=0, reg_datain=0, gnt=0.
- Invariant: reg_write | reg_inc has at most one bit set.

Decomposition:
- Package reg_bus_pkg holds:
  - state encoding: ST_IDLE, ST_ISSUE, ST_LOCKED (2-bit);
  - op constants: OP_INC=0, OP_WRITE=1;
  - default widths DW=16, AW=3.
- Sub-module rr_pick: combinational round-robin picker. Inputs are the req vector and the pointer; outputs are a one-hot winner and its index.
- The FSM, capture registers, lock counter and output decode stay in reg_bus_arbiter.

Test Plan:
- Reset, then req[0]=1, op=1, addr=2, wdata=16'h1234 -> next cycle gnt=2'b01, reg_write=8'h04, reg_datain=16'h1234; then idle with all enables 0.
- req=2'b11 held, both inc addr 5, pointer 0 -> grants alternate 01, 10, 01 on cycles 1, 3, 5; reg_inc=8'h20 on each ISSUE cycle.
- Requester 1 sets lock=1 and issues 3 writes while req[0] is held -> requester 0 gets no gnt until lock[1]=0. Requester 0 is then granted 2 cycles after lock drops.
- LOCK_MAX=4: requester 0 locks, then keeps req low -> lock_err pulses exactly once after 4 LOCKED cycles, and the state returns to IDLE.
- NREG=6: write to addr 7 -> gnt pulses and addr_err=1, reg_write=0, reg_inc=0.
- Reset asserted in the arbitration cycle of a pending write -> no enable in the next cycle, gnt=0, pointer back to 0.

Source files
------------

// File: rtl/reg_bus_arbiter_pkg.sv
// Shared encodings and defaults for the register-bus arbiter.
package reg_bus_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic OP_INC   = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int DEF_DW = 16;
  localparam int DEF_AW = 3;

  function automatic int wrap_inc(int i, int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/reg_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   idx,
  output logic            any
);

  always_comb begin
    int j;
    j   = 0;
    win = '0;
    idx = '0;
    any = |req;
    // Walk offsets high to low so the closest requester overrides.
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        win    = '0;
        win[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing a register bank between requesters,
// with optional bounded lock for atomic op sequences.
module reg_bus_arbiter
  import reg_bus_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int NREG     = 8,
  parameter int DW       = DEF_DW,
  parameter int AW       = DEF_AW,
  parameter int LOCK_MAX = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    op,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  input  logic [NREQ-1:0]    lock,
  output logic [NREQ-1:0]    gnt,
  output logic [NREG-1:0]    reg_write,
  output logic [NREG-1:0]    reg_inc,
  output logic [DW-1:0]      reg_datain,
  output logic               busy,
  output logic               addr_err,
  output logic               lock_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

  logic [1:0]      state, state_n;
  logic [PW-1:0]   ptr, owner, pick_idx, sel;
  logic [NREQ-1:0] pick_win, own_oh, gnt_n;
  logic            pick_any, go, to_err;
  logic            sel_op, sel_ok;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [CW-1:0]   cnt;
  logic [NREG-1:0] wr_n, inc_n;

  rr_pick #(
    .NREQ(NREQ),
    .PW  (PW)
  ) u_pick (
    .req(req),
    .ptr(ptr),
    .win(pick_win),
    .idx(pick_idx),
    .any(pick_any)
  );

  // While locked only the owner may be served.
  assign sel = (state == ST_LOCKED) ? owner : pick_idx;

  always_comb begin
    sel_op    = op[sel];
    sel_addr  = addr[int'(sel)*AW +: AW];
    sel_wdata = wdata[int'(sel)*DW +: DW];
    sel_ok    = int'(sel_addr) < NREG;
    own_oh        = '0;
    own_oh[owner] = 1'b1;
    gnt_n = (state == ST_LOCKED) ? own_oh : pick_win;
    wr_n  = '0;
    inc_n = '0;
    for (int r = 0; r < NREG; r++) begin
      if (sel_addr == AW'(r)) begin
        wr_n[r]  = (sel_op == OP_WRITE);
        inc_n[r] = (sel_op == OP_INC);
      end
    end
  end

  always_comb begin
    state_n = state;
    go      = 1'b0;
    to_err  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pick_any) begin
          go      = 1'b1;
          state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_n = lock[owner] ? ST_LOCKED : ST_IDLE;
      end
      ST_LOCKED: begin
        if (!lock[owner]) begin
          state_n = ST_IDLE;
        end else if (req[owner]) begin
          go      = 1'b1;
          state_n = ST_ISSUE;
        end else if (cnt == CNT_LAST) begin
          to_err  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      owner      <= '0;
      cnt        <= '0;
      gnt        <= '0;
      reg_write  <= '0;
      reg_inc    <= '0;
      reg_datain <= '0;
      busy       <= 1'b0;
      addr_err   <= 1'b0;
      lock_err   <= 1'b0;
    end else begin
      state      <= state_n;
      busy       <= (state_n != ST_IDLE);
      lock_err   <= to_err;
      gnt        <= go ? gnt_n : '0;
      reg_write  <= (go && sel_ok) ? wr_n : '0;
      reg_inc    <= (go && sel_ok) ? inc_n : '0;
      reg_datain <= (go && sel_ok && sel_op == OP_WRITE)
                    ? sel_wdata : '0;
      addr_err   <= go && !sel_ok;
      if (go) owner <= sel;
      if (state == ST_ISSUE) begin
        ptr <= PW'(wrap_inc(int'(owner), NREQ));
        cnt <= '0;
      end else if (state == ST_LOCKED) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench: random round-robin, lock, timeout and reset traffic
// checked against a transaction-level arbitration model.
module tb_reg_bus_arbiter;

  localparam int NREQ     = 3;
  localparam int NREG     = 6;
  localparam int DW       = 16;
  localparam int AW       = 3;
  localparam int LOCK_MAX = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req, op, lock, gnt;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREG-1:0]    reg_write, reg_inc;
  logic [DW-1:0]      reg_datain;
  logic               busy, addr_err, lock_err;

  reg_bus_arbiter #(
    .NREQ(NREQ), .NREG(NREG), .DW(DW), .AW(AW), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr),
    .wdata(wdata), .lock(lock), .gnt(gnt), .reg_write(reg_write),
    .reg_inc(reg_inc), .reg_datain(reg_datain), .busy(busy),
    .addr_err(addr_err), .lock_err(lock_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    logic [NREQ-1:0] g;
    logic [NREG-1:0] wr;
    logic [NREG-1:0] inc;
    logic [DW-1:0]   din;
    logic            aerr;
  } exp_t;

  exp_t sbq[$];
  int   errq[$];
  int   ord[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   mptr = 0;

  logic          op_v   [NREQ];
  logic [AW-1:0] addr_v [NREQ];
  logic [DW-1:0] wd_v   [NREQ];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, want, cyc);
    end
  endfunction

  function automatic void rand_op(int i);
    op_v[i]   = 1'($urandom_range(0, 1));
    addr_v[i] = AW'($urandom_range(0, 7));
    wd_v[i]   = DW'($urandom);
  endfunction

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      op[i]              = op_v[i];
      addr[i*AW +: AW]   = addr_v[i];
      wdata[i*DW +: DW]  = wd_v[i];
    end
  endtask

  // Expected register-side effect of requester i's current op.
  function automatic void push_exp(int c, int i);
    exp_t e;
    e.cyc  = c;
    e.g    = '0;
    e.g[i] = 1'b1;
    e.wr   = '0;
    e.inc  = '0;
    e.din  = '0;
    e.aerr = int'(addr_v[i]) >= NREG;
    if (!e.aerr) begin
      if (op_v[i]) begin
        e.wr[int'(addr_v[i])] = 1'b1;
        e.din = wd_v[i];
      end else begin
        e.inc[int'(addr_v[i])] = 1'b1;
      end
    end
    sbq.push_back(e);
  endfunction

  // Service order of a fixed request set starting from pointer p.
  function automatic void rr_fill(logic [NREQ-1:0] m, int p);
    ord.delete();
    for (int k = 0; k < NREQ; k++)
      if (m[(p + k) % NREQ]) ord.push_back((p + k) % NREQ);
  endfunction

  task automatic wait_grants(logic [NREQ-1:0] pend);
    int guard;
    guard = 0;
    while (pend != '0 && guard < 60) begin
      @(negedge clk);
      guard++;
      pend = pend & ~gnt;
      req  = req & ~gnt;
    end
    if (pend != '0) begin
      n_cmp++;
      n_err++;
      $display("FAIL grant_timeout: pending %b want 0", pend);
      req = '0;
    end
  endtask

  task automatic idle_gap();
    repeat (1 + $urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic batch(logic [NREQ-1:0] m);
    apply();
    lock = '0;
    req  = m;
    rr_fill(m, mptr);
    foreach (ord[k]) push_exp(cyc + 1 + 2 * k, ord[k]);
    mptr = (ord[ord.size() - 1] + 1) % NREQ;
    wait_grants(m);
    idle_gap();
  endtask

  task automatic lock_seq(int o, int nops, logic [NREQ-1:0] oth, int h);
    int g, d, guard;
    oth[o] = 1'b0;
    rand_op(o);
    apply();
    req     = '0;
    req[o]  = 1'b1;
    lock    = '0;
    lock[o] = 1'b1;
    push_exp(cyc + 1, o);
    for (int k = 0; k < nops; k++) begin
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (gnt[o] !== 1'b1 && guard < 60);
      if (gnt[o] !== 1'b1) begin
        n_cmp++;
        n_err++;
        $display("FAIL lock_grant_timeout: got %b want owner %0d", gnt, o);
      end
      g = cyc;
      if (k == 0) begin
        for (int i = 0; i < NREQ; i++) if (oth[i]) rand_op(i);
        req = req | oth;
      end
      if (k < nops - 1) begin
        rand_op(o);
        apply();
        push_exp(g + 2, o);
      end else begin
        apply();
        req[o] = 1'b0;
      end
    end
    repeat (1 + h) @(negedge clk);
    chk("busy_locked", busy, 1);
    lock[o] = 1'b0;
    d = cyc;
    mptr = (o + 1) % NREQ;
    if (oth != '0) begin
      rr_fill(oth, mptr);
      foreach (ord[k]) push_exp(d + 2 + 2 * k, ord[k]);
      mptr = (ord[ord.size() - 1] + 1) % NREQ;
      wait_grants(oth);
    end
    idle_gap();
  endtask

  task automatic timeout_seq(int o, logic [NREQ-1:0] oth);
    int c, guard;
    oth[o] = 1'b0;
    rand_op(o);
    apply();
    req     = '0;
    req[o]  = 1'b1;
    lock    = '0;
    lock[o] = 1'b1;
    c = cyc;
    push_exp(c + 1, o);
    errq.push_back(c + 2 + LOCK_MAX);
    @(negedge clk);
    req[o] = 1'b0;
    for (int i = 0; i < NREQ; i++) if (oth[i]) rand_op(i);
    apply();
    req  = req | oth;
    mptr = (o + 1) % NREQ;
    if (oth != '0) begin
      rr_fill(oth, mptr);
      foreach (ord[k]) push_exp(c + 3 + LOCK_MAX + 2 * k, ord[k]);
      mptr = (ord[ord.size() - 1] + 1) % NREQ;
    end
    guard = 0;
    while (lock_err !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (lock_err !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL lock_err_timeout: got %b want 1", lock_err);
    end
    lock[o] = 1'b0;
    wait_grants(oth);
    idle_gap();
  endtask

  task automatic reset_seq();
    for (int i = 0; i < NREQ; i++) rand_op(i);
    apply();
    req   = NREQ'($urandom_range(1, (1 << NREQ) - 1));
    reset = 1'b1;
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_enables", {reg_write, reg_inc}, 0);
    chk("rst_datain", reg_datain, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    req   = '0;
    mptr  = 0;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) rand_op(i);
    batch('1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (gnt !== '0) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_gnt: got %b want none at cycle %0d",
                 gnt, cyc);
      end else begin
        e = sbq.pop_front();
        chk("gnt_cycle", cyc, e.cyc);
        chk("gnt", gnt, e.g);
        chk("reg_write", reg_write, e.wr);
        chk("reg_inc", reg_inc, e.inc);
        chk("reg_datain", reg_datain, e.din);
        chk("addr_err", addr_err, e.aerr);
        chk("busy_issue", busy, 1);
      end
    end else begin
      chk("idle_outputs", {reg_write, reg_inc, reg_datain, addr_err}, 0);
    end
    chk("enable_onehot0", $onehot0(reg_write | reg_inc), 1);
    if (lock_err !== 1'b0) begin
      if (errq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_lock_err: got %b want 0 at cycle %0d",
                 lock_err, cyc);
      end else begin
        chk("lock_err_cycle", cyc, errq.pop_front());
        chk("busy_after_timeout", busy, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req   = '0;
    lock  = '0;
    op    = '0;
    addr  = '0;
    wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_v[i]   = 1'b0;
      addr_v[i] = '0;
      wd_v[i]   = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset_gnt", gnt, 0);
    chk("reset_busy", busy, 0);
    chk("reset_errs", {addr_err, lock_err}, 0);
    reset = 1'b0;
    @(negedge clk);

    op_v[0] = 1'b1; addr_v[0] = 3'd2; wd_v[0] = 16'h1234;
    batch(3'b001);

    op_v[0] = 1'b0; addr_v[0] = 3'd5;
    op_v[1] = 1'b0; addr_v[1] = 3'd5;
    batch(3'b011);

    op_v[2] = 1'b1; addr_v[2] = 3'd7; wd_v[2] = 16'hbeef;
    batch(3'b100);

    lock_seq(1, 3, 3'b001, 0);
    timeout_seq(0, 3'b010);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0: lock_seq($urandom_range(0, NREQ - 1), $urandom_range(1, 3),
                    NREQ'($urandom_range(0, 7)), $urandom_range(0, 2));
        1: timeout_seq($urandom_range(0, NREQ - 1),
                       NREQ'($urandom_range(0, 7)));
        2: reset_seq();
        default: begin
          for (int i = 0; i < NREQ; i++) rand_op(i);
          batch(NREQ'($urandom_range(1, (1 << NREQ) - 1)));
        end
      endcase
    end

    repeat (4) @(negedge clk);
    chk("sb_drain", sbq.size(), 0);
    chk("lock_err_drain", errq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
